// File: rtl/dehaze_pkg.sv
// Shared types and helpers for the dehaze pipeline stages.
package dehaze_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int PIX_MAX_W = 32;

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    RUN       = 3'd1,
    EOL       = 3'd2,
    FLUSH     = 3'd3,
    FLUSH_EOL = 3'd4
  } dm_state_t;

  // Per-slot control handed from the sequencer to the filter datapath.
  typedef struct packed {
    logic step;     // a column enters the vertical min (RUN beat or flush slot)
    logic col0;
    logic col1;
    logic eol;      // emit the right-replicated last pixel of the row
    logic top_rep;
    logic bot_rep;
    logic sof;
    logic wsel;     // line buffer currently receiving the new row
  } tap_ctl_t;

  // Operands are zero-extended by callers, so the unsigned ordering is preserved.
  function automatic logic [PIX_MAX_W-1:0] min3(input logic [PIX_MAX_W-1:0] a,
                                                input logic [PIX_MAX_W-1:0] b,
                                                input logic [PIX_MAX_W-1:0] c);
    logic [PIX_MAX_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/line_buf.sv
// Single-row delay line: read-before-write at a free-running pointer.
module line_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr  <= '0;
      dout <= '0;
    end else if (en) begin
      dout <= mem[ptr];
      ptr  <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) mem[ptr] <= din;
  end

endmodule

// File: rtl/min3x3_core.sv
// Vertical min, 3-tap horizontal window with edge replication, output register.
module min3x3_core
  import dehaze_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  tap_ctl_t              ctl,
  input  logic [DATA_WIDTH-1:0] cur_pix,
  input  logic [DATA_WIDTH-1:0] lb0_q,
  input  logic [DATA_WIDTH-1:0] lb1_q,
  output logic [DATA_WIDTH-1:0] out_pix,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic                  out_eol
);

  localparam int STAGES = 1;

  typedef logic [DATA_WIDTH-1:0] pix_t;

  function automatic pix_t m3(input pix_t a, input pix_t b, input pix_t c);
    return DATA_WIDTH'(min3(PIX_MAX_W'(a), PIX_MAX_W'(b), PIX_MAX_W'(c)));
  endfunction

  tap_ctl_t          s1;
  pix_t              s1_cur;
  pix_t              h1, h2;
  pix_t              top, mid, bot, vmin;
  logic [STAGES:0]   vld_pipe;

  // The buffer not being written holds row r-1; the one being written still reads r-2.
  always_comb begin
    mid  = s1.wsel ? lb0_q : lb1_q;
    top  = s1.top_rep ? mid : (s1.wsel ? lb1_q : lb0_q);
    bot  = s1.bot_rep ? mid : s1_cur;
    vmin = m3(top, mid, bot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s1_cur   <= '0;
      vld_pipe <= '0;
      h1       <= '0;
      h2       <= '0;
      out_pix  <= '0;
      out_sof  <= 1'b0;
      out_eol  <= 1'b0;
    end else begin
      s1       <= ctl;
      s1_cur   <= cur_pix;
      vld_pipe <= {vld_pipe[STAGES-1:0], (ctl.step && !ctl.col0) || ctl.eol};
      out_sof  <= 1'b0;
      out_eol  <= 1'b0;
      if (s1.step) begin
        h2 <= h1;
        h1 <= vmin;
        if (!s1.col0) begin
          out_pix <= m3(s1.col1 ? h1 : h2, h1, vmin);
          out_sof <= s1.sof;
        end
      end else if (s1.eol) begin
        out_pix <= m3(h2, h1, h1);
        out_eol <= 1'b1;
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: rtl/dark_min3x3.sv
// Streaming 3x3 minimum (dark-channel erosion) with replicated borders.
module dark_min3x3
  import dehaze_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_pix,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_pix,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic                  out_eol
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  dm_state_t                   state;
  logic [CW-1:0]               col;
  logic [RW-1:0]               row;
  logic                        wsel;
  logic                        acc, slot, lb_en;
  tap_ctl_t                    ctl;
  logic [1:0][DATA_WIDTH-1:0]  lb_q;

  assign acc   = in_valid && in_ready;
  assign slot  = (state == FLUSH);
  assign lb_en = acc || slot;

  always_comb begin
    ctl         = '0;
    ctl.step    = (acc && state == RUN) || slot;
    ctl.col0    = (col == '0);
    ctl.col1    = (col == CW'(1));
    ctl.eol     = (state == EOL) || (state == FLUSH_EOL);
    ctl.top_rep = (state == RUN) && (row == RW'(1));
    ctl.bot_rep = slot;
    ctl.sof     = acc && (state == RUN) && (row == RW'(1)) && (col == CW'(1));
    ctl.wsel    = wsel;
  end

  // Rows alternate between the two buffers, so one is always r-1 and the other r-2.
  for (genvar i = 0; i < 2; i++) begin : g_lb
    line_buf #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_W)
    ) u_lb (
      .clk  (clk),
      .rst_n(~rst),
      .en   (lb_en),
      .we   (acc && (wsel == 1'(i))),
      .din  (in_pix),
      .dout (lb_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      col      <= '0;
      row      <= '0;
      wsel     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        FILL, RUN: begin
          in_ready <= 1'b1;
          if (acc) begin
            if (col == COL_LAST) begin
              col  <= '0;
              wsel <= ~wsel;
              if (state == FILL) begin
                state <= RUN;
                row   <= RW'(1);
              end else begin
                state    <= EOL;
                in_ready <= 1'b0;
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        EOL: begin
          if (row == ROW_LAST) begin
            state <= FLUSH;
          end else begin
            row      <= row + RW'(1);
            state    <= RUN;
            in_ready <= 1'b1;
          end
        end
        FLUSH: begin
          if (col == COL_LAST) begin
            col   <= '0;
            state <= FLUSH_EOL;
          end else begin
            col <= col + CW'(1);
          end
        end
        FLUSH_EOL: begin
          state    <= FILL;
          row      <= '0;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= FILL;
          col      <= '0;
          row      <= '0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  min3x3_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .ctl      (ctl),
    .cur_pix  (in_pix),
    .lb0_q    (lb_q[0]),
    .lb1_q    (lb_q[1]),
    .out_pix  (out_pix),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_eol  (out_eol)
  );

endmodule

// File: tb/tb_dark_min3x3.sv
// Directed bench for dark_min3x3 on a 4x3 frame.
module tb_dark_min3x3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_pix = 8'h00;
  logic       in_ready, out_valid, out_sof, out_eol;
  logic [7:0] out_pix;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    int         t;
  } beat_t;

  beat_t obq[$];
  int    accq[$];
  logic  rdyq[$];
  bit    rec_rdy = 1'b0;

  logic [7:0] ramp[12], dark[12], exp_ramp[12], exp_dark[12];

  dark_min3x3 #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_pix   (in_pix),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_pix  (out_pix),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_eol  (out_eol)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    beat_t b;
    if (out_valid) begin
      b.pix = out_pix; b.sof = out_sof; b.eol = out_eol; b.t = cyc;
      obq.push_back(b);
    end
    if (in_valid && in_ready) accq.push_back(cyc);
    if (rec_rdy) rdyq.push_back(in_ready);
  end

  task automatic clr();
    @(posedge clk); #1;
    obq.delete(); accq.delete(); rdyq.delete();
  endtask

  task automatic send(input logic [7:0] f[12], input int n, input bit rnd);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 400) begin
      @(posedge clk); #1;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pix   = f[i];
      @(negedge clk);
      if (in_valid && in_ready) i++;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_chk++;
    if (i !== n) begin
      n_fail++;
      $display("FAIL send_accept: accepted %0d, want %0d", i, n);
    end
  endtask

  task automatic drain(input int n);
    int g = 0;
    while (obq.size() < n && g < 80) begin
      @(negedge clk);
      g++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_sof !== 1'b0)   begin n_fail++; $display("FAIL rst_out_sof: got %b want 0", out_sof); end
    if (out_eol !== 1'b0)   begin n_fail++; $display("FAIL rst_out_eol: got %b want 0", out_eol); end
    if (out_pix !== 8'h00)  begin n_fail++; $display("FAIL rst_out_pix: got %0d want 0", out_pix); end
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready0: got %b want 0", in_ready); end
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready1: got %b want 1", in_ready); end
  endtask

  task automatic test_ramp(input bit rnd);
    clr();
    send(ramp, 12, rnd);
    drain(12);
    n_chk++;
    if (obq.size() !== 12) begin n_fail++; $display("FAIL ramp_count rnd=%0d: got %0d want 12", rnd, obq.size()); end
    for (int k = 0; k < 12 && k < obq.size(); k++) begin
      n_chk += 3;
      if (obq[k].pix !== exp_ramp[k]) begin n_fail++; $display("FAIL ramp_pix[%0d] rnd=%0d: got %0d want %0d", k, rnd, obq[k].pix, exp_ramp[k]); end
      if (obq[k].sof !== (k == 0)) begin n_fail++; $display("FAIL ramp_sof[%0d]: got %b want %b", k, obq[k].sof, k == 0); end
      if (obq[k].eol !== (k % 4 == 3)) begin n_fail++; $display("FAIL ramp_eol[%0d]: got %b want %b", k, obq[k].eol, k % 4 == 3); end
    end
    // out(y,x), x<3, is due 2 cycles after input (y+1,x+1) is accepted
    if (obq.size() == 12 && accq.size() == 12) begin
      for (int y = 0; y < 2; y++) begin
        for (int x = 0; x < 3; x++) begin
          n_chk++;
          if (obq[y*4+x].t - accq[(y+1)*4+x+1] !== 2) begin
            n_fail++;
            $display("FAIL ramp_latency(%0d,%0d) rnd=%0d: got %0d want 2", y, x, rnd, obq[y*4+x].t - accq[(y+1)*4+x+1]);
          end
        end
      end
    end
  endtask

  task automatic test_handshake();
    int runs[$];
    int r = 0;
    clr();
    rec_rdy = 1'b1;
    send(ramp, 12, 1'b0);
    drain(12);
    @(posedge clk); #1;
    rec_rdy = 1'b0;
    foreach (rdyq[i]) begin
      if (!rdyq[i]) r++;
      else if (r > 0) begin runs.push_back(r); r = 0; end
    end
    if (r > 0) runs.push_back(r);
    // one EOL gap after row 1; after row 2 the EOL cycle plus 4 flush slots and flush EOL
    n_chk++;
    if (runs.size() !== 2) begin n_fail++; $display("FAIL hs_gap_count: got %0d want 2", runs.size()); end
    if (runs.size() == 2) begin
      n_chk += 2;
      if (runs[0] !== 1) begin n_fail++; $display("FAIL hs_row1_gap: got %0d want 1", runs[0]); end
      if (runs[1] !== 6) begin n_fail++; $display("FAIL hs_flush_gap: got %0d want 6", runs[1]); end
    end
    n_chk++;
    if (obq.size() !== 12) begin n_fail++; $display("FAIL hs_count: got %0d want 12", obq.size()); end
    send(ramp, 1, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_dark();
    clr();
    send(dark, 12, 1'b0);
    drain(12);
    n_chk++;
    if (obq.size() !== 12) begin n_fail++; $display("FAIL dark_count: got %0d want 12", obq.size()); end
    for (int k = 0; k < 12 && k < obq.size(); k++) begin
      n_chk++;
      if (obq[k].pix !== exp_dark[k]) begin n_fail++; $display("FAIL dark_pix[%0d]: got %0d want %0d", k, obq[k].pix, exp_dark[k]); end
    end
  endtask

  task automatic test_mid_reset();
    clr();
    send(ramp, 6, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (obq.size() !== 0) begin n_fail++; $display("FAIL midrst_no_output: got %0d beats want 0", obq.size()); end
    test_ramp(1'b0);
  endtask

  task automatic test_back_to_back();
    int eol0 = 0, eol1 = 0, sof0 = 0, sof1 = 0;
    clr();
    send(ramp, 12, 1'b0);
    send(ramp, 12, 1'b0);
    drain(24);
    n_chk++;
    if (obq.size() !== 24) begin n_fail++; $display("FAIL b2b_count: got %0d want 24", obq.size()); end
    for (int k = 0; k < 24 && k < obq.size(); k++) begin
      n_chk++;
      if (obq[k].pix !== exp_ramp[k % 12]) begin n_fail++; $display("FAIL b2b_pix[%0d]: got %0d want %0d", k, obq[k].pix, exp_ramp[k % 12]); end
      if (k < 12) begin eol0 += int'(obq[k].eol); sof0 += int'(obq[k].sof); end
      else        begin eol1 += int'(obq[k].eol); sof1 += int'(obq[k].sof); end
    end
    n_chk += 4;
    if (eol0 !== 3) begin n_fail++; $display("FAIL b2b_eol_f0: got %0d want 3", eol0); end
    if (eol1 !== 3) begin n_fail++; $display("FAIL b2b_eol_f1: got %0d want 3", eol1); end
    if (sof0 !== 1) begin n_fail++; $display("FAIL b2b_sof_f0: got %0d want 1", sof0); end
    if (sof1 !== 1) begin n_fail++; $display("FAIL b2b_sof_f1: got %0d want 1", sof1); end
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      ramp[i] = 8'(i + 1);
      dark[i] = (i == 6) ? 8'd0 : 8'd200;
    end
    exp_ramp = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd5, 8'd6, 8'd7};
    exp_dark = '{8'd200, 8'd0, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0};
    test_reset();
    test_ramp(1'b0);
    test_handshake();
    test_dark();
    test_ramp(1'b1);
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
